// File: rtl/nes_palette_ram.sv
// Writable 32-entry NES palette RAM. A reset-time sequencer loads the default palette.
// The block has one handshaked write port, two registered read ports, backdrop mirroring and a grayscale mask.
module nes_palette_ram #(
  parameter int AW        = 5,
  parameter int DW        = 6,
  parameter int OUT_W     = 8,
  parameter bit MIRROR_EN = 1'b1,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [OUT_W-1:0] rd_a_data,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [OUT_W-1:0] rd_b_data,
  input  logic             grayscale,
  output logic             init_done
);

  localparam int DEPTH = 2 ** AW;
  // Bit 4 is cleared on backdrop aliases (addr[1:0]==0). With AW<5 there is nothing to alias.
  localparam logic [AW-1:0] MIRROR_BIT = (MIRROR_EN && AW >= 5) ? AW'(16) : '0;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [OUT_W-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [4:0]        idx5;
  logic              init_we, wr_fire, mem_we;
  logic [AW-1:0]     mem_waddr, wr_phys, ra_phys, rb_phys;
  logic [DW-1:0]     mem_wdata, entry_a, entry_b;
  logic [OUT_W-1:0]  gray_mask;

  function automatic logic [7:0] default_entry(input logic [4:0] i);
    logic [7:0] v;
    case (i)
      5'd0:  v = 8'h15;  5'd1:  v = 8'h2D;  5'd2:  v = 8'h27;  5'd3:  v = 8'h30;
      5'd4:  v = 8'h15;  5'd5:  v = 8'h30;  5'd6:  v = 8'h1A;  5'd7:  v = 8'h09;
      5'd8:  v = 8'h15;  5'd9:  v = 8'h2D;  5'd10: v = 8'h27;  5'd11: v = 8'h30;
      5'd12: v = 8'h15;  5'd13: v = 8'h27;  5'd14: v = 8'h17;  5'd15: v = 8'h0F;
      5'd16: v = 8'h15;  5'd17: v = 8'h1C;  5'd18: v = 8'h15;  5'd19: v = 8'h14;
      5'd20: v = 8'h15;  5'd21: v = 8'h21;  5'd22: v = 8'h15;  5'd23: v = 8'h30;
      5'd24: v = 8'h15;  5'd25: v = 8'h1C;  5'd26: v = 8'h15;  5'd27: v = 8'h14;
      5'd28: v = 8'h15;  5'd29: v = 8'h02;  5'd30: v = 8'h38;  default: v = 8'h3C;
    endcase
    return v;
  endfunction

  function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) ? (a & ~MIRROR_BIT) : a;
  endfunction

  // Larger RAMs repeat the 32-entry table; smaller ones use its head.
  generate
    if (AW >= 5) begin : g_idx_wide
      assign idx5 = idx_q[4:0];
    end else begin : g_idx_narrow
      assign idx5 = 5'(idx_q);
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_INIT) begin
      idx_d = idx_q + 1'b1;
      if (!INIT_EN || idx_q == AW'(DEPTH - 1)) state_d = S_RUN;
    end
  end

  // Output logic
  always_comb begin
    wr_ready  = (state_q == S_RUN);
    init_done = (state_q == S_RUN);
    init_we   = (state_q == S_INIT) && INIT_EN;
  end

  // Handshake: a write is taken at a rising edge where wr_valid and wr_ready are both high and rst is low.
  // In RUN, wr_ready is always high. Writes presented during INIT or reset are dropped.
  assign wr_fire = wr_valid && wr_ready && !rst;
  assign wr_phys = phys(wr_addr);
  assign ra_phys = phys(rd_a_addr);
  assign rb_phys = phys(rd_b_addr);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_phys;
    mem_wdata = wr_data;
    if (!rst && init_we) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = DW'(default_entry(idx5));
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!INIT_EN && rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Write-first bypass when a read samples the physical address being written.
  always_comb begin
    gray_mask = grayscale ? OUT_W'(8'h30) : '1;
    entry_a   = (wr_fire && wr_phys == ra_phys) ? wr_data : mem_q[ra_phys];
    entry_b   = (wr_fire && wr_phys == rb_phys) ? wr_data : mem_q[rb_phys];
    rd_a_d    = '0;
    rd_b_d    = '0;
    if (state_q == S_RUN) begin
      rd_a_d = OUT_W'(entry_a) & gray_mask;
      rd_b_d = OUT_W'(entry_b) & gray_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;

endmodule

// File: tb/tb_nes_palette_ram.sv
// Directed bench for nes_palette_ram: init timing, mirrored sweep, writes, bypass, grayscale, mid-init reset.
// It also runs a flat-memory build.
module tb_nes_palette_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, grayscale, init_done;
  logic [4:0] wr_addr, rd_a_addr, rd_b_addr;
  logic [5:0] wr_data;
  logic [7:0] rd_a_data, rd_b_data;

  logic       f_wr_valid, f_wr_ready, f_init_done;
  logic [4:0] f_wr_addr, f_rd_a_addr, f_rd_b_addr;
  logic [5:0] f_wr_data;
  logic [7:0] f_rd_a_data, f_rd_b_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tbl [32];

  // Clock / reset
  always #5 clk = ~clk;

  nes_palette_ram dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .grayscale(grayscale), .init_done(init_done)
  );

  nes_palette_ram #(.MIRROR_EN(1'b0)) u_flat (
    .clk(clk), .rst(rst), .wr_valid(f_wr_valid), .wr_ready(f_wr_ready),
    .wr_addr(f_wr_addr), .wr_data(f_wr_data), .rd_a_addr(f_rd_a_addr), .rd_a_data(f_rd_a_data),
    .rd_b_addr(f_rd_b_addr), .rd_b_data(f_rd_b_data), .grayscale(1'b0), .init_done(f_init_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current point until init_done is high, bounded.
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      step();
      cycles++;
      if (init_done) break;
    end
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b);
    rd_a_addr = a;
    rd_b_addr = b;
    step();
  endtask

  initial begin
    int cyc;
    logic [4:0] a;
    logic [4:0] p;
    {tbl[0], tbl[1], tbl[2], tbl[3], tbl[4], tbl[5], tbl[6], tbl[7]} =
      {8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h30, 8'h1A, 8'h09};
    {tbl[8], tbl[9], tbl[10], tbl[11], tbl[12], tbl[13], tbl[14], tbl[15]} =
      {8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h27, 8'h17, 8'h0F};
    {tbl[16], tbl[17], tbl[18], tbl[19], tbl[20], tbl[21], tbl[22], tbl[23]} =
      {8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h21, 8'h15, 8'h30};
    {tbl[24], tbl[25], tbl[26], tbl[27], tbl[28], tbl[29], tbl[30], tbl[31]} =
      {8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h02, 8'h38, 8'h3C};

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_a_addr = 5'h01; rd_b_addr = 5'h02; grayscale = 1'b0;
    f_wr_valid = 1'b0; f_wr_addr = '0; f_wr_data = '0; f_rd_a_addr = '0; f_rd_b_addr = '0;
    step(); step();
    check("rst_init_done", init_done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_a", rd_a_data, 0);
    check("rst_rd_b", rd_b_data, 0);

    rst = 1'b0;
    step();
    check("init_wr_ready", wr_ready, 0);
    check("init_rd_a_zero", rd_a_data, 0);
    wait_init(cyc);
    check("init_latency", cyc + 1, 32);

    // Mirrored sweep on port A.
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      p = (a[1:0] == 2'b00) ? (a & 5'h0F) : a;
      read2(a, 5'h00);
      check($sformatf("sweep_%0h", i), rd_a_data, tbl[p]);
    end
    read2(5'h10, 5'h1D);
    check("mir_10", rd_a_data, 8'h15);
    check("mir_1d", rd_b_data, 8'h02);
    read2(5'h1F, 5'h1F);
    check("mir_1f_a", rd_a_data, 8'h3C);
    check("mir_1f_b", rd_b_data, 8'h3C);

    // Write through a mirrored address.
    check("run_wr_ready", wr_ready, 1);
    wr_valid = 1'b1; wr_addr = 5'h10; wr_data = 6'h21;
    step();
    wr_valid = 1'b0;
    read2(5'h00, 5'h10);
    check("wr10_rd00_a", rd_a_data, 8'h21);
    check("wr10_rd10_b", rd_b_data, 8'h21);
    read2(5'h11, 5'h00);
    check("wr10_rd11_a", rd_a_data, 8'h1C);
    check("wr10_rd00_b", rd_b_data, 8'h21);

    // Same-cycle write and read: write-first bypass.
    wr_valid = 1'b1; wr_addr = 5'h05; wr_data = 6'h0A;
    read2(5'h05, 5'h06);
    wr_valid = 1'b0;
    check("bypass_a", rd_a_data, 8'h0A);
    check("bypass_b_other", rd_b_data, 8'h1A);
    read2(5'h06, 5'h05);
    check("after_bypass_b", rd_b_data, 8'h0A);

    // Grayscale is registered with the address.
    grayscale = 1'b1;
    rd_a_addr = 5'h02; rd_b_addr = 5'h1E;
    @(posedge clk); #1;
    grayscale = 1'b0;
    #1;
    check("gray_02", rd_a_data, 8'h20);
    check("gray_1e", rd_b_data, 8'h30);
    step();
    check("nogray_02", rd_a_data, 8'h27);
    check("nogray_1e", rd_b_data, 8'h38);

    // Accepted write that the later re-init must overwrite.
    wr_valid = 1'b1; wr_addr = 5'h03; wr_data = 6'h3F;
    step();
    wr_valid = 1'b0;
    read2(5'h03, 5'h03);
    check("wr03_pre_rst", rd_a_data, 8'h3F);

    // Restart init, reset again at index 12 with a write present.
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'h07; wr_data = 6'h3F;
    for (int i = 0; i < 12; i++) step();
    check("mid_init_wr_ready", wr_ready, 0);
    check("mid_init_done", init_done, 0);
    rst = 1'b1; wr_addr = 5'h03;
    step();
    check("rerst_init_done", init_done, 0);
    check("rerst_wr_ready", wr_ready, 0);
    check("rerst_rd_a", rd_a_data, 0);
    check("rerst_rd_b", rd_b_data, 0);
    rst = 1'b0;
    wait_init(cyc);
    wr_valid = 1'b0;
    check("reinit_latency", cyc, 32);
    read2(5'h03, 5'h05);
    check("reinit_03", rd_a_data, 8'h30);
    check("reinit_05", rd_b_data, 8'h30);
    read2(5'h10, 5'h07);
    check("reinit_10", rd_a_data, 8'h15);
    check("reinit_07", rd_b_data, 8'h09);

    // Flat build: 0x10 is its own entry.
    check("flat_init_done", f_init_done, 1);
    f_wr_valid = 1'b1; f_wr_addr = 5'h10; f_wr_data = 6'h3F;
    step();
    f_wr_valid = 1'b0;
    f_rd_a_addr = 5'h00; f_rd_b_addr = 5'h10;
    step();
    check("flat_rd00", f_rd_a_data, 8'h15);
    check("flat_rd10", f_rd_b_data, 8'h3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
